// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin arbiter sharing one ALU port between NUM_REQ
// issue queues, with a registered stallable issue stage and an early wakeup
// tag pipeline of depth ALU_LATENCY.
// Optional feature macro: ALU_ISSUE_ARB_STALL_CNT_EN (saturating stall counter).

package common;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_t;
endpackage

module alu_issue_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  common::alu_cmd_t      req_alu_cmd [NUM_REQ],
  input  logic [31:0]           req_op1     [NUM_REQ],
  input  logic [31:0]           req_op2     [NUM_REQ],
  input  logic [7:0]            req_phys_rd [NUM_REQ],
  output logic [NUM_REQ-1:0]    req_grant,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output common::alu_cmd_t      ex_alu_cmd,
  output logic [31:0]           ex_op1,
  output logic [31:0]           ex_op2,
  output logic [7:0]            ex_phys_rd,
  output logic                  wakeup_valid,
  output logic [7:0]            wakeup_tag,
  output logic [31:0]           stall_cycles
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Modular pointer add; explicit compare keeps NUM_REQ=3 wrapping correct.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_ex_vld_p0;
  common::alu_cmd_t  r_ex_cmd_p0;
  logic [31:0]       r_ex_op1_p0;
  logic [31:0]       r_ex_op2_p0;
  logic [7:0]        r_ex_rd_p0;
  logic [ALU_LATENCY-1:0] r_wk_vld_p;
  logic [7:0]        r_wk_tag_p [ALU_LATENCY];

  logic              w_can_issue;
  logic              w_accept;
  logic              w_grant_any;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [NUM_REQ-1:0] w_grant;

  assign w_can_issue = !r_ex_vld_p0 || ex_ready;
  assign w_accept    = r_ex_vld_p0 && ex_ready;

  // Round-robin search starting at r_rr_ptr; first ready requester wins.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    if (w_can_issue && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_grant_any && req_valid[ptr_add(r_rr_ptr, k)]) begin
          w_grant_any = 1'b1;
          w_grant_idx = ptr_add(r_rr_ptr, k);
        end
      end
      if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign req_grant = w_grant;

  // Round-robin pointer advances past each granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= ptr_add(w_grant_idx, 1);
    end
  end

  // ---- stage p0: issue register feeding the ALU ----
  // Issue stage: load on grant, drain on accept, drop on flush, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_vld_p0 <= 1'b0;
      r_ex_cmd_p0 <= common::ALU_ADD;
      r_ex_op1_p0 <= '0;
      r_ex_op2_p0 <= '0;
      r_ex_rd_p0  <= '0;
    end else if (flush) begin
      r_ex_vld_p0 <= 1'b0;
    end else if (w_grant_any) begin
      r_ex_vld_p0 <= 1'b1;
      r_ex_cmd_p0 <= req_alu_cmd[w_grant_idx];
      r_ex_op1_p0 <= req_op1[w_grant_idx];
      r_ex_op2_p0 <= req_op2[w_grant_idx];
      r_ex_rd_p0  <= req_phys_rd[w_grant_idx];
    end else if (ex_ready) begin
      r_ex_vld_p0 <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_vld_p0;
  assign ex_alu_cmd = r_ex_cmd_p0;
  assign ex_op1     = r_ex_op1_p0;
  assign ex_op2     = r_ex_op2_p0;
  assign ex_phys_rd = r_ex_rd_p0;

  // ---- stages p1..pN: wakeup tag shift pipeline ----
  // Accepted tags shift toward the tail; flush wipes every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wk_vld_p <= '0;
      for (int s = 0; s < ALU_LATENCY; s++) r_wk_tag_p[s] <= '0;
    end else if (flush) begin
      r_wk_vld_p <= '0;
      for (int s = 0; s < ALU_LATENCY; s++) r_wk_tag_p[s] <= '0;
    end else begin
      r_wk_vld_p[0] <= w_accept;
      r_wk_tag_p[0] <= w_accept ? r_ex_rd_p0 : 8'h00;
      for (int s = 1; s < ALU_LATENCY; s++) begin
        r_wk_vld_p[s] <= r_wk_vld_p[s-1];
        r_wk_tag_p[s] <= r_wk_tag_p[s-1];
      end
    end
  end

  assign wakeup_valid = r_wk_vld_p[ALU_LATENCY-1];
  assign wakeup_tag   = r_wk_tag_p[ALU_LATENCY-1];

`ifdef ALU_ISSUE_ARB_STALL_CNT_EN
  // Saturating increment so the counter parks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;

  // Count cycles where a valid op is held back by the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (r_ex_vld_p0 && !ex_ready) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares one ALU execution port between `NUM_REQ` issue queues. Each cycle it selects one ready entry by round-robin and grants it to its queue. It captures the selected operands into a registered, stallable issue stage feeding the ALU. It also emits an early wakeup tag broadcast `ALU_LATENCY` cycles after each accepted issue, which drives the queues' `phys_result_valid/tag` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesting issue queues (2..4)
- `ALU_LATENCY`, 1, cycles from ALU accept to result-tag broadcast (1..4)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  [NUM_REQ]  queue i has a ready entry
- `req_alu_cmd`  in  [NUM_REQ] x common::alu_cmd_t  command per requester
- `req_op1`, `req_op2`  in  [NUM_REQ] x 32  operands per requester
- `req_phys_rd`  in  [NUM_REQ] x 8  destination tag per requester
- `req_grant`  out  [NUM_REQ]  one-hot, combinational; queue i dequeues its entry this cycle when set
- `flush`  in  1  pipeline flush
- `ex_ready`  in  1  ALU accepts the issue stage this cycle
- `ex_valid`  out  1  issue stage holds a valid op
- `ex_alu_cmd`  out  common::alu_cmd_t  registered command
- `ex_op1`, `ex_op2`  out  32  registered operands
- `ex_phys_rd`  out  8  registered destination tag
- `wakeup_valid`  out  1  result-tag broadcast valid
- `wakeup_tag`  out  8  broadcast tag
- `stall_cycles`  out  32  stall counter (see Configuration)

## Operation
- `can_issue = !ex_valid || ex_ready`.
- Grant:
  - When `can_issue && !flush`, grant the first requester with `req_valid` set.
  - Search order is `rr_ptr`, `rr_ptr+1`, … mod `NUM_REQ`.
  - Otherwise `req_grant = 0`.
  - At most one grant bit is set.
- On grant to i:
  - `ex_*` load requester i's fields at the next edge.
  - `ex_valid` goes to 1.
  - `rr_ptr` becomes `(i+1) mod NUM_REQ`.
- Accept without a new grant (`ex_ready` with no request): `ex_valid` goes to 0 at the next edge.
- Stall (`ex_valid && !ex_ready`): `ex_*` hold, `req_grant = 0`, `rr_ptr` holds.
- Accept (`ex_valid && ex_ready`): push `ex_phys_rd` into a tag shift pipeline of depth `ALU_LATENCY`. The pipeline's tail drives `wakeup_valid/wakeup_tag`.
- Flush (priority over everything):
  - No grant.
  - At the next edge: `ex_valid` = 0, all wakeup pipeline entries cleared, including an accept occurring in the flush cycle.
  - `rr_ptr` unchanged.
- Reset values:
  - `ex_valid` = 0; `ex_alu_cmd`/`ex_op1`/`ex_op2`/`ex_phys_rd` = 0.
  - `rr_ptr` = 0.
  - Wakeup pipeline all 0, so `wakeup_valid` = 0 and `wakeup_tag` = 0.
  - `stall_cycles` = 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Ops in flight are dropped.
- `rr_ptr` width is `$clog2(NUM_REQ)`. The increment wraps from `NUM_REQ-1` to 0, and must also wrap correctly for non-power-of-2 values (`NUM_REQ` = 3).

## Timing
- Grant is combinational in cycle t. The op appears on `ex_*` with `ex_valid` in cycle t+1.
- Back-to-back issue: with `ex_ready` held at 1, one op issues per cycle.
- Accept in cycle t gives `wakeup_valid` in cycle t+`ALU_LATENCY`, for exactly one cycle per accept.
- Flush in cycle t: `ex_valid` = 0 and `wakeup_valid` = 0 in cycle t+1.
- No combinational path from `ex_ready` to `ex_*`. There is a combinational path from `ex_ready`/`req_valid`/`flush` to `req_grant`.

## Configuration
- `ALU_ISSUE_ARB_STALL_CNT_EN` defined:
  - `stall_cycles` increments by 1 every cycle with `ex_valid && !ex_ready`.
  - It saturates at 0xFFFFFFFF.
  - Reset and `flush` clear it to 0.
- Not defined: `stall_cycles` is tied to 0 and no counter flops exist.

## Test plan
- Reset release, no requests → `ex_valid`=0, `wakeup_valid`=0, `req_grant`=0 for 10 cycles.
- `NUM_REQ`=2, both `req_valid`=1 continuously, `ex_ready`=1 → grants alternate 01, 10, 01, 10. `ex_phys_rd` follows the granted tags (0x05, 0x0A, …) one cycle later.
- Single op tag 0x21 granted at t=3, `ex_ready`=0 at t=4..6, =1 at t=7 → `ex_*` held through t=7, `req_grant`=0 during t=4..6, `wakeup_valid` with tag 0x21 at t=7+`ALU_LATENCY`. With the macro defined, `stall_cycles`=3.
- `ALU_LATENCY`=3: accepts of tags 0x01, 0x02, 0x03 in consecutive cycles t..t+2 → `wakeup_tag` 0x01, 0x02, 0x03 at t+3..t+5.
- Flush in the cycle tag 0x10 is accepted while 0x0F is mid-pipeline (`ALU_LATENCY`=2) → no `wakeup_valid` for either, `ex_valid`=0 the next cycle, `rr_ptr` unchanged.
- `NUM_REQ`=3, `rr_ptr`=2, only `req_valid[0]`=1 → `req_grant`=001 and `rr_ptr` becomes 1. Then `req_valid`=111 → grants 010, 100, 001.
